tl_ul_periph_regs: RTL and testbench

TileLink-UL slave socket terminating the 24 MHz peripheral crossbar's slave-side A/D channels in a bank of memory-mapped 32-bit registers. Accepts Get, PutFullData and PutPartialData, returns AccessAckData or AccessAck with error signalling, and keeps one transaction outstanding. The register contents are exported as a flat vector for peripheral logic.

---
 rtl/tl_pkg.sv | 29 ++
 rtl/tl_ul_addr_decode.sv | 47 ++++
 rtl/tl_ul_periph_regs.sv | 147 ++++++++++++++
 tb/tb_tl_ul_periph_regs.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the peripheral register socket: opcodes,
// FSM state encoding and the latched D-channel response record.
package tl_pkg;

  localparam int TL_OP_W   = 3;
  localparam int TL_SIZE_W = 3;
  localparam int TL_SRC_W  = 2;
  localparam int TL_DATA_W = 32;

  localparam logic [TL_OP_W-1:0] TL_PUT_FULL        = 3'd0;
  localparam logic [TL_OP_W-1:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [TL_OP_W-1:0] TL_GET             = 3'd4;
  localparam logic [TL_OP_W-1:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [TL_OP_W-1:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } tl_state_e;

  typedef struct packed {
    logic [TL_OP_W-1:0]   opcode;
    logic [TL_SIZE_W-1:0] size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_DATA_W-1:0] data;
    logic                 error;
  } tl_d_rsp_t;

endpackage

// File: rtl/tl_ul_addr_decode.sv
// Combinational A-beat decode: register index plus a single error flag covering
// opcode, size, alignment and address-range violations.
module tl_ul_addr_decode
  import tl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    NUM_REGS     = 8,
  parameter int                    IDX_W        = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [SIZE_WIDTH-1:0]   size,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [IDX_W-1:0]        index,
  output logic                    error
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;
  logic                  op_ok;
  logic                  size_ok;
  logic                  align_ok;
  logic                  below;
  logic                  out_of_range;

  always_comb begin
    offset       = address - BASE_ADDR;
    word         = offset >> 2;
    op_ok        = (opcode == TL_GET) || (opcode == TL_PUT_FULL) ||
                   (opcode == TL_PUT_PARTIAL);
    size_ok      = (size <= SIZE_WIDTH'(2));
    align_ok     = 1'b0;
    case (size)
      SIZE_WIDTH'(0): align_ok = 1'b1;
      SIZE_WIDTH'(1): align_ok = ~address[0];
      SIZE_WIDTH'(2): align_ok = (address[1:0] == 2'b00);
      default:        align_ok = 1'b0;
    endcase
    below        = (address < BASE_ADDR);
    out_of_range = (word >= ADDR_WIDTH'(NUM_REGS));
    index        = word[IDX_W-1:0];
    error        = ~op_ok | ~size_ok | ~align_ok | below | out_of_range;
  end

endmodule

// File: rtl/tl_ul_periph_regs.sv
// TileLink-UL slave terminating A/D channels in a bank of 32-bit registers, one
// transaction outstanding. Optional TL_REGS_ID_REG_EN makes register 0 a read-only ID.
module tl_ul_periph_regs
  import tl_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    SRC_WIDTH    = 2,
  parameter int                    SINK_WIDTH   = 1,
  parameter int                    OPCODE_WIDTH = 3,
  parameter int                    PARAM_WIDTH  = 3,
  parameter int                    NUM_REGS     = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE     = 32'h544C_0001
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [OPCODE_WIDTH-1:0]        a_opcode,
  input  logic [PARAM_WIDTH-1:0]         a_param,
  input  logic [SIZE_WIDTH-1:0]          a_size,
  input  logic [SRC_WIDTH-1:0]           a_source,
  input  logic [ADDR_WIDTH-1:0]          a_address,
  input  logic [MASK_WIDTH-1:0]          a_mask,
  input  logic [DATA_WIDTH-1:0]          a_data,
  output logic                           d_valid,
  input  logic                           d_ready,
  output logic [OPCODE_WIDTH-1:0]        d_opcode,
  output logic [PARAM_WIDTH-1:0]         d_param,
  output logic [SIZE_WIDTH-1:0]          d_size,
  output logic [SRC_WIDTH-1:0]           d_source,
  output logic [SINK_WIDTH-1:0]          d_sink,
  output logic [DATA_WIDTH-1:0]          d_data,
  output logic                           d_error,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  // state   | meaning
  // IDLE    | a_ready high, waiting for an A beat
  // RESP    | response latched, d_valid high until d_ready

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  tl_state_e             state_q, state_d;
  tl_d_rsp_t             rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [IDX_W-1:0] dec_index;
  logic             dec_error;
  logic             is_get;
  logic             is_put;
  logic             acc_error;

  logic unused_a_param;
  assign unused_a_param = ^a_param;

  tl_ul_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SIZE_WIDTH  (SIZE_WIDTH),
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .NUM_REGS    (NUM_REGS),
    .IDX_W       (IDX_W),
    .BASE_ADDR   (BASE_ADDR)
  ) u_decode (
    .address(a_address),
    .size   (a_size),
    .opcode (a_opcode),
    .index  (dec_index),
    .error  (dec_error)
  );

  function automatic logic [DATA_WIDTH-1:0] reset_value(input int idx);
`ifdef TL_REGS_ID_REG_EN
    return (idx == 0) ? ID_VALUE : '0;
`else
    return (idx == 0) ? '0 : '0;
`endif
  endfunction

  always_comb begin
    is_get    = (a_opcode == TL_GET);
    is_put    = (a_opcode == TL_PUT_FULL) || (a_opcode == TL_PUT_PARTIAL);
    acc_error = dec_error;
`ifdef TL_REGS_ID_REG_EN
    // The ID register never takes a write; the Put is refused rather than ignored.
    if (is_put && (dec_index == '0)) acc_error = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    regs_d  = regs_q;
    case (state_q)
      ST_IDLE: begin
        if (a_valid) begin
          rsp_d.opcode = is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
          rsp_d.size   = a_size;
          rsp_d.source = a_source;
          rsp_d.error  = acc_error;
          rsp_d.data   = (is_get && !acc_error) ? regs_q[dec_index] : '0;
          if (is_put && !acc_error) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
              if (a_mask[b]) regs_d[dec_index][8*b +: 8] = a_data[8*b +: 8];
            end
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (d_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rsp_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reset_value(i);
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      regs_q  <= regs_d;
    end
  end

  assign a_ready  = (state_q == ST_IDLE);
  assign d_valid  = (state_q == ST_RESP);
  assign d_opcode = rsp_q.opcode;
  assign d_size   = rsp_q.size;
  assign d_source = rsp_q.source;
  assign d_data   = rsp_q.data;
  assign d_error  = rsp_q.error;
  assign d_param  = '0;
  assign d_sink   = '0;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
    assign reg_q[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_tl_ul_periph_regs.sv
// Scoreboard bench for tl_ul_periph_regs; expectations come from a bench-side
// register model, with the ID-register build selected by TL_REGS_ID_REG_EN.
module tb_tl_ul_periph_regs;

  localparam int          NUM_REGS = 8;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam logic [31:0] ID_VAL   = 32'h544C_0001;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [1:0]  src;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic        d_valid, d_ready;
  logic [2:0]  d_opcode, d_param, d_size;
  logic [1:0]  d_source;
  logic [0:0]  d_sink;
  logic [31:0] d_data;
  logic        d_error;
  logic [255:0] reg_q;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] m_regs [NUM_REGS];
  logic [31:0] last_data;
  logic        last_err;
  logic [2:0]  last_op;

  tl_ul_periph_regs dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .d_error(d_error), .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
`ifdef TL_REGS_ID_REG_EN
    m_regs[0] = ID_VAL;
`endif
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = m_regs[i];
    return f;
  endfunction

  function automatic exp_t model_apply(input logic [2:0] op, input logic [31:0] addr,
                                       input logic [2:0] size, input logic [3:0] mask,
                                       input logic [31:0] data, input logic [1:0] src);
    exp_t e;
    logic [31:0] w;
    logic err, put;
    w   = (addr - BASE) >> 2;
    put = (op == 3'd0) || (op == 3'd1);
    err = !(put || op == 3'd4);
    if (size > 3'd2) err = 1'b1;
    if (size == 3'd1 && addr[0]) err = 1'b1;
    if (size == 3'd2 && addr[1:0] != 2'b00) err = 1'b1;
    if (addr < BASE) err = 1'b1;
    if (w >= NUM_REGS) err = 1'b1;
`ifdef TL_REGS_ID_REG_EN
    if (put && w == 0) err = 1'b1;
`endif
    e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
    e.size = size;
    e.src  = src;
    e.err  = err;
    e.data = (!err && op == 3'd4) ? m_regs[w[2:0]] : 32'h0;
    if (!err && put)
      for (int b = 0; b < 4; b++)
        if (mask[b]) m_regs[w[2:0]][8*b +: 8] = data[8*b +: 8];
    return e;
  endfunction

  task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic [1:0] src);
    a_opcode = op; a_address = addr; a_size = size; a_mask = mask; a_data = data;
    a_source = src; a_param = 3'd0;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [2:0] size,
                      input logic [3:0] mask, input logic [31:0] data, input logic [1:0] src);
    int n;
    @(negedge clk);
    a_valid = 1'b1;
    drive_a(op, addr, size, mask, data, src);
    n = 0;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    if (!a_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout a_ready=%b required 1", a_ready);
      a_valid = 1'b0;
      return;
    end
    sb.push_back(model_apply(op, addr, size, mask, data, src));
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b1) begin
      errors++; $display("FAIL latency d_valid=%b required 1", d_valid);
    end
    checks++;
    if (reg_q !== model_flat()) begin
      errors++; $display("FAIL reg_q got %h required %h", reg_q, model_flat());
    end
  endtask

  task automatic recv();
    int n;
    exp_t e;
    n = 0;
    while (!d_valid && n < 20) begin @(negedge clk); n++; end
    if (!d_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout d_valid=%b required 1", d_valid);
      return;
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_resp d_valid=1 required no response");
      return;
    end
    e = sb.pop_front();
    last_data = d_data; last_err = d_error; last_op = d_opcode;
    checks++;
    if (d_opcode !== e.op) begin
      errors++; $display("FAIL d_opcode got %0d required %0d", d_opcode, e.op);
    end
    checks++;
    if (d_data !== e.data) begin
      errors++; $display("FAIL d_data got %h required %h", d_data, e.data);
    end
    checks++;
    if (d_error !== e.err) begin
      errors++; $display("FAIL d_error got %b required %b", d_error, e.err);
    end
    checks++;
    if (d_size !== e.size || d_source !== e.src || d_param !== 3'd0 || d_sink !== 1'b0) begin
      errors++;
      $display("FAIL d_fields got size=%0d src=%0d param=%0d sink=%0d required size=%0d src=%0d param=0 sink=0",
               d_size, d_source, d_param, d_sink, e.size, e.src);
    end
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b0 || a_ready !== 1'b1) begin
      errors++; $display("FAIL after_fire d_valid=%b a_ready=%b required 0 1", d_valid, a_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
    drive_a(3'd0, 32'h0, 3'd0, 4'h0, 32'h0, 2'd0);
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      errors++; $display("FAIL reset_handshake a_ready=%b d_valid=%b required 1 0", a_ready, d_valid);
    end
    checks++;
    if ({d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error} !== '0) begin
      errors++; $display("FAIL reset_dfields got %h %h required 0", d_opcode, d_data);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (reg_q !== model_flat()) begin
      errors++; $display("FAIL reset_regs got %h required %h", reg_q, model_flat());
    end
  endtask

  task automatic test_get_basic();
    send(3'd4, BASE + 32'd4, 3'd2, 4'hF, 32'h0, 2'd2);
    recv();
    checks++;
    if (last_op !== 3'd1 || last_data !== 32'h0 || last_err !== 1'b0) begin
      errors++; $display("FAIL get_basic got op=%0d data=%h err=%b required 1 0 0", last_op, last_data, last_err);
    end
  endtask

  task automatic test_put_get();
    send(3'd0, BASE + 32'd8, 3'd2, 4'hF, 32'hDEADBEEF, 2'd1);
    checks++;
    if (reg_q[95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL put_visible got %h required deadbeef", reg_q[95:64]);
    end
    recv();
    send(3'd4, BASE + 32'd8, 3'd2, 4'hF, 32'h0, 2'd1);
    recv();
    checks++;
    if (last_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL get_after_put got %h required deadbeef", last_data);
    end
  endtask

  task automatic test_partial();
    send(3'd1, BASE + 32'd8, 3'd2, 4'b0100, 32'h00AB0000, 2'd3);
    recv();
    send(3'd4, BASE + 32'd8, 3'd2, 4'hF, 32'h0, 2'd0);
    recv();
    checks++;
    if (last_data !== 32'hDEABBEEF) begin
      errors++; $display("FAIL partial got %h required deabbeef", last_data);
    end
  endtask

  task automatic test_errors();
    send(3'd4, BASE + 32'd4 * NUM_REGS, 3'd2, 4'hF, 32'h0, 2'd0); recv();
    send(3'd4, BASE + 32'd2, 3'd2, 4'hF, 32'h0, 2'd1);              recv();
    send(3'd2, BASE + 32'd4, 3'd2, 4'hF, 32'h11111111, 2'd2);       recv();
    checks++;
    if (last_op !== 3'd0 || last_err !== 1'b1) begin
      errors++; $display("FAIL arith_err got op=%0d err=%b required 0 1", last_op, last_err);
    end
    send(3'd4, BASE + 32'd8, 3'd3, 4'hF, 32'h0, 2'd3);              recv();
    send(3'd0, BASE + 32'd9, 3'd1, 4'h2, 32'h0000FF00, 2'd0);       recv();
    send(3'd0, BASE + 32'd36, 3'd2, 4'hF, 32'h55555555, 2'd1);      recv();
    send(3'd4, BASE + 32'd9, 3'd0, 4'h2, 32'h0, 2'd2);              recv();
    send(3'd4, BASE + 32'd28, 3'd2, 4'hF, 32'h0, 2'd3);             recv();
  endtask

  task automatic test_id_reg();
    send(3'd0, BASE, 3'd2, 4'hF, 32'hA5A5A5A5, 2'd0); recv();
    send(3'd4, BASE, 3'd2, 4'hF, 32'h0, 2'd1);        recv();
`ifdef TL_REGS_ID_REG_EN
    checks++;
    if (last_data !== ID_VAL) begin
      errors++; $display("FAIL id_read got %h required %h", last_data, ID_VAL);
    end
`else
    checks++;
    if (last_data !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL reg0_rw got %h required a5a5a5a5", last_data);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [2:0] s_op; logic [31:0] s_data; logic s_err; logic [1:0] s_src;
    exp_t e1;
    @(negedge clk);
    a_valid = 1'b1;
    drive_a(3'd4, BASE + 32'd8, 3'd2, 4'hF, 32'h0, 2'd1);
    sb.push_back(model_apply(3'd4, BASE + 32'd8, 3'd2, 4'hF, 32'h0, 2'd1));
    @(posedge clk); #1;
    drive_a(3'd0, BASE + 32'd16, 3'd2, 4'hF, 32'h12345678, 2'd3);
    @(negedge clk);
    e1 = sb.pop_front();
    s_op = d_opcode; s_data = d_data; s_err = d_error; s_src = d_source;
    checks++;
    if (s_op !== e1.op || s_data !== e1.data || s_err !== e1.err || s_src !== e1.src) begin
      errors++; $display("FAIL bp_first got op=%0d data=%h err=%b required %0d %h %b",
                         s_op, s_data, s_err, e1.op, e1.data, e1.err);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a_ready !== 1'b0 || d_valid !== 1'b1 || d_opcode !== s_op || d_data !== s_data ||
          d_error !== s_err || d_source !== s_src) begin
        errors++; $display("FAIL bp_hold cycle %0d a_ready=%b d_valid=%b data=%h required 0 1 %h",
                           i, a_ready, d_valid, d_data, s_data);
      end
      @(negedge clk);
    end
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0 || reg_q[159:128] !== m_regs[4]) begin
      errors++; $display("FAIL bp_fire a_ready=%b d_valid=%b reg4=%h required 1 0 %h",
                         a_ready, d_valid, reg_q[159:128], m_regs[4]);
    end
    sb.push_back(model_apply(3'd0, BASE + 32'd16, 3'd2, 4'hF, 32'h12345678, 2'd3));
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (d_valid !== 1'b1 || reg_q[159:128] !== 32'h12345678) begin
      errors++; $display("FAIL bp_second d_valid=%b reg4=%h required 1 12345678", d_valid, reg_q[159:128]);
    end
    recv();
  endtask

  task automatic test_reset_mid();
    send(3'd0, BASE + 32'd12, 3'd2, 4'hF, 32'hCAFEF00D, 2'd2);
    #1 reset = 1'b0;
    #1;
    model_reset();
    sb.delete();
    checks++;
    if (d_valid !== 1'b0 || reg_q !== model_flat()) begin
      errors++; $display("FAIL reset_mid d_valid=%b reg_q=%h required 0 %h", d_valid, reg_q, model_flat());
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (d_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset_resp d_valid=%b required 0", d_valid);
      end
    end
    send(3'd4, BASE + 32'd12, 3'd2, 4'hF, 32'h0, 2'd0);
    recv();
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: op = 3'd0;
        1: op = 3'd1;
        2: op = 3'd2;
        default: op = 3'd4;
      endcase
      send(op, BASE + 32'd4 * $urandom_range(0, 9) + (($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0),
           3'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 3)));
      recv();
    end
  endtask

  initial begin
    test_reset();
    test_get_basic();
    test_put_get();
    test_partial();
    test_errors();
    test_id_reg();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
